// File: rtl/i2c_master.sv
// Byte-level I2C master: one START, address byte, single write or read data
// byte, then STOP. Drives open-drain tri-state controls (1 = release line) and
// senses the real line levels for ACK, read data and clock stretching.
module i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_START,
  input  logic       I_RW,
  input  logic [6:0] I_ADDR,
  input  logic [7:0] I_WDATA,
  input  logic       I_SDA_IN,
  input  logic       I_SCL_IN,
  output logic       O_SDA_T,
  output logic       O_SCL_T,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_ACK_ERR,
  output logic [7:0] O_RDATA
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(CLK_DIV - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_AACK  = 4'd3;
  localparam logic [3:0] S_WR    = 4'd4;
  localparam logic [3:0] S_WACK  = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;
  localparam logic [3:0] S_MNACK = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0]       state, state_n;
  logic [1:0]       phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       tx_sr, tx_n;
  logic [7:0]       rx_sr, rx_n;
  logic [7:0]       wdata_q;
  logic             rw_q;
  logic             ack_n;
  logic [7:0]       rdata_n;
  logic             accept;
  logic             tick;

  // Line controls {scl_t, sda_t} for the state/phase being entered, so the
  // pins change on the same edge the FSM enters that phase.
  function automatic logic [1:0] line_drive(input logic [3:0] st,
                                            input logic [1:0] ph,
                                            input logic       b);
    logic [1:0] r;
    logic       scl_hi;
    scl_hi = (ph == 2'd1) || (ph == 2'd2);
    r = 2'b11;
    case (st)
      S_START: begin
        case (ph)
          2'd0:    r = 2'b11;
          2'd3:    r = 2'b00;
          default: r = 2'b10;
        endcase
      end
      S_ADDR, S_WR:                 r = {scl_hi, b};
      S_AACK, S_WACK, S_RD, S_MNACK: r = {scl_hi, 1'b1};
      S_STOP: begin
        case (ph)
          2'd0:    r = 2'b00;
          2'd3:    r = 2'b11;
          default: r = 2'b10;
        endcase
      end
      default: r = 2'b11;
    endcase
    return r;
  endfunction

  assign accept = (state == S_IDLE) && !O_DONE && I_START;
  assign tick   = (cnt == TICK_AT);

  // Next-state logic: tick counter, phase sequencing, shifting and ACK sampling
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    tx_n    = tx_sr;
    rx_n    = rx_sr;
    ack_n   = O_ACK_ERR;
    rdata_n = O_RDATA;
    case (state)
      S_IDLE: begin
        cnt_n   = '0;
        phase_n = 2'd0;
        if (accept) begin
          state_n = S_START;
          tx_n    = {I_ADDR, I_RW};
          bit_n   = 3'd0;
          ack_n   = 1'b0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        phase_n = 2'd0;
        if (rw_q && !O_ACK_ERR) rdata_n = rx_sr;
      end
      default: begin
        if (phase == 2'd1 && !I_SCL_IN) begin
          // slave is stretching SCL: hold the phase until the line rises
          cnt_n = '0;
        end else if (tick) begin
          cnt_n   = '0;
          phase_n = phase + 2'd1;
          if (phase == 2'd2) begin
            if (state == S_RD) rx_n = {rx_sr[6:0], I_SDA_IN};
            if ((state == S_AACK || state == S_WACK) && I_SDA_IN) ack_n = 1'b1;
          end
          if (phase == 2'd3) begin
            case (state)
              S_START: begin
                state_n = S_ADDR;
                bit_n   = 3'd0;
              end
              S_ADDR, S_WR: begin
                tx_n = {tx_sr[6:0], 1'b0};
                if (bit_cnt == 3'd7) state_n = (state == S_ADDR) ? S_AACK : S_WACK;
                else bit_n = bit_cnt + 3'd1;
              end
              S_AACK: begin
                bit_n = 3'd0;
                if (O_ACK_ERR)  state_n = S_STOP;
                else if (rw_q)  state_n = S_RD;
                else begin
                  state_n = S_WR;
                  tx_n    = wdata_q;
                end
              end
              S_RD: begin
                if (bit_cnt == 3'd7) state_n = S_MNACK;
                else bit_n = bit_cnt + 3'd1;
              end
              S_WACK, S_MNACK: state_n = S_STOP;
              S_STOP:          state_n = S_DONE;
              default:         state_n = S_IDLE;
            endcase
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      O_SDA_T   <= 1'b1;
      O_SCL_T   <= 1'b1;
      O_BUSY    <= 1'b0;
      O_DONE    <= 1'b0;
      O_ACK_ERR <= 1'b0;
      O_RDATA   <= 8'h00;
    end else begin
      state                <= state_n;
      phase                <= phase_n;
      cnt                  <= cnt_n;
      bit_cnt              <= bit_n;
      {O_SCL_T, O_SDA_T}   <= line_drive(state_n, phase_n, tx_n[7]);
      O_BUSY               <= (state_n != S_IDLE);
      O_DONE               <= (state == S_DONE);
      O_ACK_ERR            <= ack_n;
      O_RDATA              <= rdata_n;
    end
  end

  // Datapath shift registers and captured request fields
  always_ff @(posedge I_CLK) begin
    tx_sr <= tx_n;
    rx_sr <= rx_n;
    if (accept) begin
      wdata_q <= I_WDATA;
      rw_q    <= I_RW;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with CLK_DIV=4: a pullup plus open-drain
// slave responder, a table of transactions and a few hand-written sequences.
module tb_i2c_master;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       sda_t, scl_t, busy, done, ack_err;
  logic [7:0] rdata;
  logic       sda_line, scl_line;

  int errors = 0;
  int checks = 0;

  // slave configuration for the running transaction
  logic       cfg_present = 1'b0;
  logic       cfg_data_ack = 1'b0;
  logic       cfg_rw = 1'b0;
  logic [7:0] cfg_rd = 8'h00;
  int         cfg_stretch_at = 0;

  // bus observer / responder state
  int   falls = 0, rises = 0, starts = 0, stops = 0, stretch_left = 0;
  logic busy_prev = 1'b0, scl_t_prev = 1'b1, scl_prev = 1'b1, sda_prev = 1'b1;
  logic log_sda [0:31];
  logic slave_pull;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       present;
    logic       data_ack;
    logic [7:0] rd_byte;
    int         stretch_at;
    int         exp_cyc;
    logic       exp_err;
    logic [7:0] exp_rdata;
    logic [17:0] exp_bits;
    int         nbits;
  } vec_t;

  vec_t vecs [7];

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_START(start), .I_RW(rw), .I_ADDR(addr),
    .I_WDATA(wdata), .I_SDA_IN(sda_line), .I_SCL_IN(scl_line),
    .O_SDA_T(sda_t), .O_SCL_T(scl_t), .O_BUSY(busy), .O_DONE(done),
    .O_ACK_ERR(ack_err), .O_RDATA(rdata)
  );

  always #5 clk = ~clk;

  assign sda_line = sda_t & ~slave_pull;
  assign scl_line = scl_t & (stretch_left == 0);

  // Bit period b lies between SCL falls b+1 and b+2 (fall 1 ends START).
  always_comb begin
    slave_pull = 1'b0;
    if (cfg_present) begin
      if (falls == 9) slave_pull = 1'b1;
      else if (!cfg_rw && falls == 18) slave_pull = cfg_data_ack;
      else if (cfg_rw && falls >= 10 && falls <= 17) slave_pull = ~cfg_rd[3'(17 - falls)];
    end
  end

  always @(negedge clk) begin
    busy_prev  <= busy;
    scl_t_prev <= scl_t;
    scl_prev   <= scl_line;
    sda_prev   <= sda_line;
    if (busy && !busy_prev) begin
      falls <= 0; rises <= 0; starts <= 0; stops <= 0; stretch_left <= 0;
    end else begin
      if (scl_line && scl_prev && sda_prev && !sda_line) starts <= starts + 1;
      if (scl_line && scl_prev && !sda_prev && sda_line) stops <= stops + 1;
      if (scl_t && !scl_t_prev) begin
        if (rises < 32) log_sda[rises] <= sda_line;
        rises <= rises + 1;
      end
      if (!scl_t && scl_t_prev) falls <= falls + 1;
      if (scl_t && !scl_t_prev && cfg_stretch_at == rises + 1) stretch_left <= 50;
      else if (stretch_left > 0) stretch_left <= stretch_left - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic run(input vec_t v, input string tag, input logic inj_busy, input logic inj_done);
    int cyc;
    logic [17:0] got_bits;
    cfg_present    = v.present;
    cfg_data_ack   = v.data_ack;
    cfg_rw         = v.rw;
    cfg_rd         = v.rd_byte;
    cfg_stretch_at = v.stretch_at;
    @(negedge clk);
    start = 1'b1; rw = v.rw; addr = v.addr; wdata = v.wdata;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inj_busy && cyc == 50) begin
        start = 1'b1; addr = 7'h11; rw = ~v.rw; wdata = 8'h00;
      end
      if (done) break;
    end
    check({tag, " done_cycle"}, cyc, v.exp_cyc);
    check({tag, " ack_err"}, {31'd0, ack_err}, {31'd0, v.exp_err});
    check({tag, " rdata"}, {24'd0, rdata}, {24'd0, v.exp_rdata});
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    got_bits = '0;
    for (int i = 0; i < v.nbits; i++) got_bits = {got_bits[16:0], log_sda[i]};
    check({tag, " sda_bits"}, {14'd0, got_bits}, {14'd0, v.exp_bits});
    check({tag, " scl_pulses"}, rises, v.nbits + 1);
    check({tag, " start_cond"}, starts, 1);
    check({tag, " stop_cond"}, stops, 1);
    if (inj_done) begin
      start = 1'b1; addr = 7'h22; rw = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " start_in_done_ignored"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic saw_done;
    vecs[0] = '{rw:1'b0, addr:7'h50, wdata:8'hA5, present:1'b1, data_ack:1'b1, rd_byte:8'h00,
                stretch_at:0, exp_cyc:322, exp_err:1'b0, exp_rdata:8'h00,
                exp_bits:18'b1010000_0_0_10100101_0, nbits:18};
    vecs[1] = '{rw:1'b1, addr:7'h3B, wdata:8'h00, present:1'b1, data_ack:1'b0, rd_byte:8'h3C,
                stretch_at:0, exp_cyc:322, exp_err:1'b0, exp_rdata:8'h3C,
                exp_bits:18'b0111011_1_0_00111100_1, nbits:18};
    vecs[2] = '{rw:1'b0, addr:7'h50, wdata:8'hA5, present:1'b0, data_ack:1'b0, rd_byte:8'h00,
                stretch_at:0, exp_cyc:178, exp_err:1'b1, exp_rdata:8'h3C,
                exp_bits:18'b000000000_1010000_0_1, nbits:9};
    vecs[3] = '{rw:1'b0, addr:7'h50, wdata:8'hA5, present:1'b1, data_ack:1'b1, rd_byte:8'h00,
                stretch_at:4, exp_cyc:372, exp_err:1'b0, exp_rdata:8'h3C,
                exp_bits:18'b1010000_0_0_10100101_0, nbits:18};
    vecs[4] = '{rw:1'b0, addr:7'h2A, wdata:8'hFF, present:1'b1, data_ack:1'b0, rd_byte:8'h00,
                stretch_at:0, exp_cyc:322, exp_err:1'b1, exp_rdata:8'h3C,
                exp_bits:18'b0101010_0_0_11111111_1, nbits:18};
    vecs[5] = '{rw:1'b1, addr:7'h7F, wdata:8'h00, present:1'b1, data_ack:1'b0, rd_byte:8'h81,
                stretch_at:0, exp_cyc:322, exp_err:1'b0, exp_rdata:8'h81,
                exp_bits:18'b1111111_1_0_10000001_1, nbits:18};
    vecs[6] = '{rw:1'b1, addr:7'h01, wdata:8'h00, present:1'b0, data_ack:1'b0, rd_byte:8'h00,
                stretch_at:0, exp_cyc:178, exp_err:1'b1, exp_rdata:8'h81,
                exp_bits:18'b000000000_0000001_1_1, nbits:9};

    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("reset sda_t", {31'd0, sda_t}, 32'd1);
    check("reset scl_t", {31'd0, scl_t}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset ack_err", {31'd0, ack_err}, 32'd0);
    check("reset rdata", {24'd0, rdata}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("vec%0d", i), 1'b0, 1'b0);

    // reset asserted at cycle 100 of a write aborts it
    cfg_present = 1'b1; cfg_data_ack = 1'b1; cfg_rw = 1'b0; cfg_stretch_at = 0;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h50; wdata = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort sda_t", {31'd0, sda_t}, 32'd1);
    check("abort scl_t", {31'd0, scl_t}, 32'd1);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort no_done", {31'd0, saw_done}, 32'd0);

    // after reset: normal write, with a start pulse while busy and one in the done cycle
    run(vecs[0], "busy_inject", 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
